// File: rtl/avalon_mm_csr_bridge_if.sv
// Avalon-MM slave plus register-bank request/ready bus of the CSR bridge.
// Ports (bundled signals):
//   avl_mm_*   : Avalon-MM command, wait, read data, response strobes
//   sys_read_* : one-hot read request, ready, data, response code
//   sys_write_*: one-hot write request, ready, strobes, data
// Modports: slave = bridge view, master = interconnect / register-bank view.
interface avalon_mm_csr_bridge_if #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned REGISTERS_NUMBER = 4
);
    logic [ADDR_WIDTH-1:0]       avl_mm_addr;
    logic                        avl_mm_read;
    logic                        avl_mm_write;
    logic [DATA_WIDTH-1:0]       avl_mm_writedata;
    logic [DATA_WIDTH/8-1:0]     avl_mm_byteenable;
    logic                        avl_mm_waitrequest;
    logic [DATA_WIDTH-1:0]       avl_mm_readdata;
    logic                        avl_mm_readdatavalid;
    logic                        avl_mm_writeresponsevalid;
    logic [1:0]                  avl_mm_response;

    logic [REGISTERS_NUMBER-1:0] sys_read_req;
    logic                        sys_read_ready;
    logic [DATA_WIDTH-1:0]       sys_read_data;
    logic [1:0]                  sys_read_resp;
    logic [REGISTERS_NUMBER-1:0] sys_write_req;
    logic                        sys_write_ready;
    logic [DATA_WIDTH/8-1:0]     sys_write_strb;
    logic [DATA_WIDTH-1:0]       sys_write_data;

    modport slave (
        input  avl_mm_addr, avl_mm_read, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
        output avl_mm_waitrequest, avl_mm_readdata, avl_mm_readdatavalid,
        output avl_mm_writeresponsevalid, avl_mm_response,
        output sys_read_req, sys_write_req, sys_write_strb, sys_write_data,
        input  sys_read_ready, sys_read_data, sys_read_resp, sys_write_ready
    );

    modport master (
        output avl_mm_addr, avl_mm_read, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
        input  avl_mm_waitrequest, avl_mm_readdata, avl_mm_readdatavalid,
        input  avl_mm_writeresponsevalid, avl_mm_response,
        input  sys_read_req, sys_write_req, sys_write_strb, sys_write_data,
        output sys_read_ready, sys_read_data, sys_read_resp, sys_write_ready
    );
endinterface

// File: rtl/avalon_mm_csr_bridge.sv
// Avalon-MM slave that decodes single-word accesses onto a one-hot register-bank
// request/ready bus, with decode-error, per-access timeout and registered responses.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   io_bus : avalon_mm_csr_bridge_if.slave (Avalon-MM slave + register-bank side)
module avalon_mm_csr_bridge #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned REGISTERS_NUMBER = 4,
    parameter logic [REGISTERS_NUMBER*ADDR_WIDTH-1:0] MEMORY_MAP = '0,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    avalon_mm_csr_bridge_if.slave io_bus
);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;
    localparam logic [15:0] TimeoutLast =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                      r_state;
    logic                        r_is_read;
    logic [REGISTERS_NUMBER-1:0] r_rd_req;
    logic [REGISTERS_NUMBER-1:0] r_wr_req;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic [DATA_WIDTH/8-1:0]     r_strb;
    logic [DATA_WIDTH-1:0]       r_rdata;
    logic [1:0]                  r_resp;
    logic                        r_rdv;
    logic                        r_wrv;
    logic [15:0]                 r_cnt;

    logic [REGISTERS_NUMBER-1:0] w_hit;
    logic                        w_found;
    logic                        w_accept;
    logic                        w_ready;

    // Lowest matching map entry wins, so at most one hit bit is set.
    always_comb begin
        w_hit   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < REGISTERS_NUMBER; i++) begin
            if (!w_found && io_bus.avl_mm_addr == MEMORY_MAP[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_hit[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign w_accept = (r_state == StIdle) && (io_bus.avl_mm_read || io_bus.avl_mm_write);
    assign w_ready  = r_is_read ? io_bus.sys_read_ready : io_bus.sys_write_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_is_read <= 1'b0;
            r_rd_req  <= '0;
            r_wr_req  <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_rdata   <= '0;
            r_resp    <= RespOkay;
            r_rdv     <= 1'b0;
            r_wrv     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        // Read has priority when both commands are asserted.
                        r_is_read <= io_bus.avl_mm_read;
                        if (!io_bus.avl_mm_read) begin
                            r_wdata <= io_bus.avl_mm_writedata;
                            r_strb  <= io_bus.avl_mm_byteenable;
                        end
                        if (!w_found) begin
                            r_state <= StResp;
                            r_resp  <= RespDecErr;
                            r_rdv   <= io_bus.avl_mm_read;
                            r_wrv   <= !io_bus.avl_mm_read;
                        end else if (!io_bus.avl_mm_read && io_bus.avl_mm_byteenable == '0) begin
                            // Nothing to write: complete locally without touching the bank.
                            r_state <= StResp;
                            r_resp  <= RespOkay;
                            r_wrv   <= 1'b1;
                        end else begin
                            r_state <= StAccess;
                            r_cnt   <= '0;
                            if (io_bus.avl_mm_read) begin
                                r_rd_req <= w_hit;
                            end else begin
                                r_wr_req <= w_hit;
                            end
                        end
                    end
                end
                StAccess: begin
                    // Completion takes priority over a timeout on the same edge.
                    if (w_ready) begin
                        r_rd_req <= '0;
                        r_wr_req <= '0;
                        r_state  <= StResp;
                        if (r_is_read) begin
                            r_rdv   <= 1'b1;
                            r_rdata <= io_bus.sys_read_data;
                            r_resp  <= io_bus.sys_read_resp;
                        end else begin
                            r_wrv  <= 1'b1;
                            r_resp <= RespOkay;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && r_cnt == TimeoutLast) begin
                        r_rd_req <= '0;
                        r_wr_req <= '0;
                        r_state  <= StResp;
                        r_resp   <= RespSlvErr;
                        r_rdata  <= '0;
                        r_rdv    <= r_is_read;
                        r_wrv    <= !r_is_read;
                    end else if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StResp: begin
                    r_rdv   <= 1'b0;
                    r_wrv   <= 1'b0;
                    r_resp  <= RespOkay;
                    r_rdata <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.avl_mm_waitrequest        = (r_state != StIdle);
    assign io_bus.avl_mm_readdata           = r_rdata;
    assign io_bus.avl_mm_readdatavalid      = r_rdv;
    assign io_bus.avl_mm_writeresponsevalid = r_wrv;
    assign io_bus.avl_mm_response           = r_resp;
    assign io_bus.sys_read_req              = r_rd_req;
    assign io_bus.sys_write_req             = r_wr_req;
    assign io_bus.sys_write_strb            = r_strb;
    assign io_bus.sys_write_data            = r_wdata;
endmodule

// File: tb/tb_avalon_mm_csr_bridge.sv
// Self-checking bench for avalon_mm_csr_bridge: directed accesses push expected
// responses, request episodes and waitrequest lengths into queues; monitors pop
// and compare on the falling clock edge.
module tb_avalon_mm_csr_bridge;
    logic clk;
    logic rst_n;

    avalon_mm_csr_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .REGISTERS_NUMBER(4)) bus ();

    avalon_mm_csr_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .REGISTERS_NUMBER(4),
        .MEMORY_MAP(16'h3210),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic is_rd; logic [1:0] resp; logic [31:0] data;} rsp_t;
    typedef struct {logic is_rd; logic [3:0] vec; int cycles;} req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   wait_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_rsp(input logic rd, input logic [1:0] resp, input logic [31:0] data);
        rsp_t r;
        r.is_rd = rd; r.resp = resp; r.data = data;
        rsp_q.push_back(r);
    endtask

    task automatic exp_req(input logic rd, input logic [3:0] vec, input int cycles);
        req_t r;
        r.is_rd = rd; r.vec = vec; r.cycles = cycles;
        req_q.push_back(r);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (bus.avl_mm_readdatavalid || bus.avl_mm_writeresponsevalid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp_kind_rdv", {31'd0, bus.avl_mm_readdatavalid}, {31'd0, e.is_rd});
                check("rsp_kind_wrv", {31'd0, bus.avl_mm_writeresponsevalid}, {31'd0, !e.is_rd});
                check("rsp_code", {30'd0, bus.avl_mm_response}, {30'd0, e.resp});
                check("rsp_readdata", bus.avl_mm_readdata, e.data);
            end
        end else begin
            check("idle_readdata", bus.avl_mm_readdata, 32'd0);
            check("idle_response", {30'd0, bus.avl_mm_response}, 32'd0);
        end
    end

    // Request-episode monitor.
    int         req_cnt = 0;
    logic [7:0] req_vec = '0;
    always @(negedge clk) begin
        logic [7:0] cur;
        cur = {bus.sys_read_req, bus.sys_write_req};
        if (cur != 8'd0) begin
            if (req_cnt > 0 && cur != req_vec) check("req_steady", {24'd0, cur}, {24'd0, req_vec});
            req_vec = cur;
            req_cnt++;
        end else if (req_cnt > 0) begin
            if (req_q.size() == 0) begin
                check("unexpected_request", {24'd0, req_vec}, 32'd0);
            end else begin
                req_t e;
                e = req_q.pop_front();
                check("req_vector", {24'd0, req_vec},
                      e.is_rd ? {24'd0, e.vec, 4'd0} : {28'd0, e.vec});
                check("req_cycles", req_cnt, e.cycles);
            end
            req_cnt = 0;
        end
    end

    // Waitrequest-length monitor.
    int wr_cnt = 0;
    always @(negedge clk) begin
        if (bus.avl_mm_waitrequest) begin
            wr_cnt++;
        end else if (wr_cnt > 0) begin
            if (wait_q.size() == 0) begin
                check("unexpected_waitrequest", wr_cnt, 0);
            end else begin
                check("waitrequest_cycles", wr_cnt, wait_q.pop_front());
            end
            wr_cnt = 0;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.avl_mm_waitrequest) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                check("waitrequest_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // ready_at: ACCESS cycles before ready is raised (-1 = never).
    // abort_at: ACCESS cycles before reset is pulsed (-1 = never).
    task automatic access(input logic rd, input logic wr, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int ready_at,
                          input logic [31:0] rdat, input logic [1:0] rresp, input int abort_at);
        wait_idle();
        bus.avl_mm_addr       = addr;
        bus.avl_mm_read       = rd;
        bus.avl_mm_write      = wr;
        bus.avl_mm_writedata  = wd;
        bus.avl_mm_byteenable = be;
        @(posedge clk); #1;
        bus.avl_mm_read  = 1'b0;
        bus.avl_mm_write = 1'b0;
        if (ready_at >= 0) begin
            for (int c = 0; c < ready_at; c++) begin @(posedge clk); #1; end
            if (rd) begin
                bus.sys_read_ready = 1'b1;
                bus.sys_read_data  = rdat;
                bus.sys_read_resp  = rresp;
            end else begin
                bus.sys_write_ready = 1'b1;
            end
            @(posedge clk); #1;
            bus.sys_read_ready  = 1'b0;
            bus.sys_write_ready = 1'b0;
            bus.sys_read_data   = '0;
            bus.sys_read_resp   = '0;
        end
        if (abort_at >= 0) begin
            for (int c = 0; c < abort_at; c++) begin @(posedge clk); #1; end
            #1 rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.avl_mm_addr       = '0;
        bus.avl_mm_read       = 1'b0;
        bus.avl_mm_write      = 1'b0;
        bus.avl_mm_writedata  = '0;
        bus.avl_mm_byteenable = '0;
        bus.sys_read_ready    = 1'b0;
        bus.sys_read_data     = '0;
        bus.sys_read_resp     = '0;
        bus.sys_write_ready   = 1'b0;

        #12;
        check("reset_waitrequest", {31'd0, bus.avl_mm_waitrequest}, 32'd0);
        check("reset_read_req", {28'd0, bus.sys_read_req}, 32'd0);
        check("reset_write_req", {28'd0, bus.sys_write_req}, 32'd0);
        check("reset_write_data", bus.sys_write_data, 32'd0);
        check("reset_write_strb", {28'd0, bus.sys_write_strb}, 32'd0);
        check("reset_strobes", {30'd0, bus.avl_mm_readdatavalid, bus.avl_mm_writeresponsevalid},
              32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read hit, ready in first ACCESS cycle.
        exp_rsp(1'b1, 2'b00, 32'hDEADBEEF); exp_req(1'b1, 4'b0100, 1); wait_q.push_back(2);
        access(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 0, 32'hDEADBEEF, 2'b00, -1);

        // Write hit, ready after three request cycles.
        exp_rsp(1'b0, 2'b00, 32'h0); exp_req(1'b0, 4'b0010, 3); wait_q.push_back(4);
        access(1'b0, 1'b1, 4'd1, 32'h12345678, 4'h5, 2, 32'h0, 2'b00, -1);
        check("write_strb", {28'd0, bus.sys_write_strb}, 32'h5);
        check("write_data", bus.sys_write_data, 32'h12345678);

        // Read miss; write data must hold across it.
        exp_rsp(1'b1, 2'b11, 32'h0); wait_q.push_back(1);
        access(1'b1, 1'b0, 4'd7, 32'h0, 4'h0, -1, 32'h0, 2'b00, -1);
        check("write_data_hold", bus.sys_write_data, 32'h12345678);

        // Write miss.
        exp_rsp(1'b0, 2'b11, 32'h0); wait_q.push_back(1);
        access(1'b0, 1'b1, 4'd7, 32'hAAAA0000, 4'hF, -1, 32'h0, 2'b00, -1);

        // Timeout on read, ready never raised.
        exp_rsp(1'b1, 2'b10, 32'h0); exp_req(1'b1, 4'b0001, 4); wait_q.push_back(5);
        access(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, -1, 32'h0, 2'b00, -1);

        // Ready on the last timeout cycle: completion wins.
        exp_rsp(1'b1, 2'b00, 32'hCAFEF00D); exp_req(1'b1, 4'b1000, 4); wait_q.push_back(5);
        access(1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 3, 32'hCAFEF00D, 2'b00, -1);

        // Empty-strobe write: OKAY, no bank request.
        exp_rsp(1'b0, 2'b00, 32'h0); wait_q.push_back(1);
        access(1'b0, 1'b1, 4'd2, 32'h55AA55AA, 4'h0, -1, 32'h0, 2'b00, -1);

        // Read and write together: read performed, write data not captured.
        exp_rsp(1'b1, 2'b00, 32'h0BADF00D); exp_req(1'b1, 4'b0010, 1); wait_q.push_back(2);
        access(1'b1, 1'b1, 4'd1, 32'hFFFFFFFF, 4'hF, 0, 32'h0BADF00D, 2'b00, -1);
        check("rw_write_data_kept", bus.sys_write_data, 32'h55AA55AA);
        check("rw_write_strb_kept", {28'd0, bus.sys_write_strb}, 32'h0);

        // Slave error passed through from the register bank.
        exp_rsp(1'b1, 2'b10, 32'h11112222); exp_req(1'b1, 4'b0001, 2); wait_q.push_back(3);
        access(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1, 32'h11112222, 2'b10, -1);

        // Ready while idle must be ignored.
        bus.sys_read_ready = 1'b1; bus.sys_write_ready = 1'b1;
        @(posedge clk); #1;
        bus.sys_read_ready = 1'b0; bus.sys_write_ready = 1'b0;
        @(posedge clk); #1;

        // Reset during a pending read: request drops, no response.
        exp_req(1'b1, 4'b0100, 2); wait_q.push_back(2);
        access(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, -1, 32'h0, 2'b00, 2);
        check("post_reset_write_data", bus.sys_write_data, 32'd0);

        // Normal read after the reset.
        exp_rsp(1'b1, 2'b00, 32'h600DCAFE); exp_req(1'b1, 4'b0010, 1); wait_q.push_back(2);
        access(1'b1, 1'b0, 4'd1, 32'h0, 4'h0, 0, 32'h600DCAFE, 2'b00, -1);

        repeat (4) @(posedge clk);
        #1;
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);
        check("wait_queue_drained", wait_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
